// File: rtl/zle_enc.sv
// Zero run-length encoder: runs of zero words become run-count tokens,
// nonzero words pass through as literals, EOS is forwarded as a token.
// Mealy outputs; all handshake outputs are combinational from state and inputs.
module zle_enc #(
   parameter int W      = 16,
   parameter int MAXRUN = 16
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_v,
   input  logic [W-1:0] i_d,
   input  logic         i_eos,
   output logic         i_b,
   output logic         o_v,
   output logic [W-1:0] o_d,
   output logic         o_run,
   output logic         o_eos,
   input  logic         o_b
);

   localparam int CW = $clog2(MAXRUN+1);

   localparam logic [1:0] START    = 2'd0;
   localparam logic [1:0] ZEROS    = 2'd1;
   localparam logic [1:0] PENDING  = 2'd2;
   localparam logic [1:0] EOS_PEND = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  hold_q, hold_d;

   logic          ib, ov, orun, oeos;
   logic [W-1:0]  od;
   logic          zero;

   assign zero = !i_eos && (i_d == '0);

   // next-state and token selection; nothing moves while the consumer stalls
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      ib      = 1'b1;
      ov      = 1'b0;
      od      = '0;
      orun    = 1'b0;
      oeos    = 1'b0;
      case (state_q)
         START: begin
            if (!o_b) begin
               ib = 1'b0;
               if (i_v) begin
                  if (i_eos) begin
                     ov   = 1'b1;
                     oeos = 1'b1;
                  end else if (zero) begin
                     cnt_d   = CW'(1);
                     state_d = ZEROS;
                  end else begin
                     ov = 1'b1;
                     od = i_d;
                  end
               end
            end
         end
         ZEROS: begin
            if (!o_b) begin
               ib = 1'b0;
               if (i_v) begin
                  if (i_eos) begin
                     ov      = 1'b1;
                     orun    = 1'b1;
                     od      = W'(cnt_q);
                     state_d = EOS_PEND;
                  end else if (zero) begin
                     if (cnt_q == CW'(MAXRUN)) begin
                        // full run goes out; this zero opens the next run
                        ov    = 1'b1;
                        orun  = 1'b1;
                        od    = W'(cnt_q);
                        cnt_d = CW'(1);
                     end else begin
                        cnt_d = cnt_q + CW'(1);
                     end
                  end else begin
                     ov      = 1'b1;
                     orun    = 1'b1;
                     od      = W'(cnt_q);
                     hold_d  = i_d;
                     state_d = PENDING;
                  end
               end
            end
         end
         PENDING: begin
            if (!o_b) begin
               ov      = 1'b1;
               od      = hold_q;
               hold_d  = '0;
               state_d = START;
            end
         end
         EOS_PEND: begin
            if (!o_b) begin
               ov      = 1'b1;
               oeos    = 1'b1;
               cnt_d   = '0;
               state_d = START;
            end
         end
         default: begin
            state_d = 'x;
            cnt_d   = 'x;
            hold_d  = 'x;
            ib      = 1'bx;
            ov      = 1'bx;
            od      = 'x;
            orun    = 1'bx;
            oeos    = 1'bx;
         end
      endcase
   end

   // state, run counter and held literal
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= START;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   // outputs forced idle while reset is asserted
   always_comb begin
      i_b   = !reset || ib;
      o_v   = reset && ov;
      o_d   = reset ? od : '0;
      o_run = reset && orun;
      o_eos = reset && oeos;
   end

endmodule

// File: tb/tb_zle_enc.sv
// Bench for zle_enc: two instances (W=16/MAXRUN=16 and W=8/MAXRUN=255),
// directed scenarios plus a randomized stream, against a token-list model.
module tb_zle_enc;

   logic        clock = 1'b0;
   logic        reset = 1'b0;

   logic        v16 = 1'b0, e16 = 1'b0, ob16 = 1'b0;
   logic [15:0] d16 = '0;
   logic        ib16, ov16, or16, oe16;
   logic [15:0] od16;

   logic        v8 = 1'b0, e8 = 1'b0, ob8 = 1'b0;
   logic [7:0]  d8 = '0;
   logic        ib8, ov8, or8, oe8;
   logic [7:0]  od8;

   int checks = 0;
   int errors = 0;
   bit rnd_ob = 1'b0;

   // token = {dut id, eos, run, 16-bit value}
   logic [18:0] expq[$];
   logic [18:0] gotq[$];
   int          run[2];

   always #5 clock = ~clock;

   zle_enc #(.W(16), .MAXRUN(16)) u16 (
      .clock(clock), .reset(reset), .i_v(v16), .i_d(d16), .i_eos(e16), .i_b(ib16),
      .o_v(ov16), .o_d(od16), .o_run(or16), .o_eos(oe16), .o_b(ob16));

   zle_enc #(.W(8), .MAXRUN(255)) u8 (
      .clock(clock), .reset(reset), .i_v(v8), .i_d(d8), .i_eos(e8), .i_b(ib8),
      .o_v(ov8), .o_d(od8), .o_run(or8), .o_eos(oe8), .o_b(ob8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference: close a zero run of length n as ceil-split chunks of maxrun
   task automatic term(input int k);
      int maxr, full;
      maxr = (k == 1) ? 255 : 16;
      if (run[k] > 0) begin
         full = (run[k] - 1) / maxr;
         repeat (full) expq.push_back({k[0], 1'b0, 1'b1, 16'(maxr)});
         expq.push_back({k[0], 1'b0, 1'b1, 16'(run[k] - full * maxr)});
      end
      run[k] = 0;
   endtask

   task automatic ref_step(input int k, input bit eos, input int d);
      if (eos) begin
         term(k);
         expq.push_back({k[0], 1'b1, 1'b0, 16'h0});
      end else if (d == 0) begin
         run[k]++;
      end else begin
         term(k);
         expq.push_back({k[0], 1'b0, 1'b0, 16'(d)});
      end
   endtask

   // collect emitted tokens and check per-token invariants
   always @(negedge clock) begin
      if (reset && ov16 && !ob16) begin
         gotq.push_back({1'b0, oe16, or16, od16});
         if (or16) chk("run16_range", 32'(od16 >= 1 && od16 <= 16), 1);
         else if (oe16) chk("eos16_d", 32'(od16), 0);
         else chk("lit16_nonzero", 32'(od16 != 0), 1);
      end
      if (reset && ov8 && !ob8) begin
         gotq.push_back({1'b1, oe8, or8, 8'h0, od8});
         if (or8) chk("run8_range", 32'(od8 >= 1), 1);
         else if (oe8) chk("eos8_d", 32'(od8), 0);
         else chk("lit8_nonzero", 32'(od8 != 0), 1);
      end
   end

   always @(posedge clock) begin
      #1;
      if (rnd_ob) ob16 = ($urandom_range(0, 9) < 3);
   end

   task automatic send16(input bit eos, input int d);
      int n = 0;
      @(posedge clock); #1;
      v16 = 1'b1; e16 = eos; d16 = 16'(d);
      @(negedge clock);
      while (ib16 && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) chk("send16_timeout", 1, 0);
      else ref_step(0, eos, d);
   endtask

   task automatic send8(input bit eos, input int d);
      int n = 0;
      @(posedge clock); #1;
      v8 = 1'b1; e8 = eos; d8 = 8'(d);
      @(negedge clock);
      while (ib8 && n < 100) begin @(negedge clock); n++; end
      if (n >= 100) chk("send8_timeout", 1, 0);
      else ref_step(1, eos, d);
   endtask

   task automatic stop();
      @(posedge clock); #1;
      v16 = 1'b0; v8 = 1'b0; e16 = 1'b0; e8 = 1'b0;
   endtask

   task automatic flush(input string tag);
      int m;
      repeat (4) @(negedge clock);
      chk({tag, "_count"}, 32'(gotq.size()), 32'(expq.size()));
      m = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
      for (int i = 0; i < m; i++) chk({tag, "_tok"}, 32'(gotq[i]), 32'(expq[i]));
      gotq.delete();
      expq.delete();
   endtask

   initial begin
      run[0] = 0; run[1] = 0;
      // reset: outputs idle even with a valid nonzero input presented
      v16 = 1'b1; d16 = 16'h5; v8 = 1'b1; d8 = 8'h5;
      #12;
      chk("rst_ib", 32'(ib16), 1);
      chk("rst_ov", 32'(ov16), 0);
      chk("rst_od", 32'(od16), 0);
      chk("rst_orun", 32'({or16, oe16}), 0);
      chk("rst_ov8", 32'(ov8), 0);
      v16 = 1'b0; v8 = 1'b0; d16 = '0; d8 = '0;
      @(posedge clock); #1 reset = 1'b1;

      // 5,0,0,0,7 -> lit5 run3 lit7; PENDING cycle shows i_b=1
      send16(0, 5); send16(0, 0); send16(0, 0); send16(0, 0); send16(0, 7);
      stop();
      @(negedge clock);
      chk("pend_ib", 32'(ib16), 1);
      chk("pend_lit", 32'({ov16, od16}), 32'({1'b1, 16'd7}));
      @(negedge clock);
      chk("after_pend_ib", 32'(ib16), 0);
      chk("after_pend_ov", 32'(ov16), 0);
      flush("basic");

      // 35 zeros then 9 -> 16,16,3,lit9
      repeat (35) send16(0, 0);
      send16(0, 9);
      stop();
      flush("longrun");

      // 0,0,EOS -> run2, EOS next cycle, then lit4
      send16(0, 0); send16(0, 0); send16(1, 0);
      stop();
      @(negedge clock);
      chk("eospend_ib", 32'(ib16), 1);
      chk("eospend_tok", 32'({ov16, oe16, or16, od16}), 32'({3'b110, 16'd0}));
      send16(0, 4);
      stop();
      flush("eos");

      // back-pressure held during PENDING
      send16(0, 0); send16(0, 16'h00AB);
      @(posedge clock); #1 v16 = 1'b0; ob16 = 1'b1;
      repeat (5) begin
         @(negedge clock);
         chk("bp_ov", 32'(ov16), 0);
         chk("bp_ib", 32'(ib16), 1);
      end
      @(posedge clock); #1 ob16 = 1'b0;
      @(negedge clock);
      chk("bp_release", 32'({ov16, or16, od16}), 32'({2'b10, 16'h00AB}));
      flush("backpressure");

      // reset mid-run discards cnt=6
      repeat (6) send16(0, 0);
      @(posedge clock); #1 reset = 1'b0; d16 = 16'h3;
      #1;
      chk("midrst_ov", 32'(ov16), 0);
      chk("midrst_ib", 32'(ib16), 1);
      run[0] = 0;
      v16 = 1'b0;
      @(posedge clock); #1 reset = 1'b1;
      send16(0, 0); send16(0, 1);
      stop();
      flush("midreset");

      // randomized stream with random consumer stalls
      rnd_ob = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) send16(1, 0);
         else if ($urandom_range(0, 2) == 0) send16(0, int'($urandom_range(1, 65535)));
         else send16(0, 0);
      end
      send16(0, 1);
      stop();
      rnd_ob = 1'b0;
      @(posedge clock); #1 ob16 = 1'b0;
      flush("random");

      // W=8, MAXRUN=255: 255 zeros then 1, then EOS from START
      repeat (255) send8(0, 0);
      send8(0, 1);
      send8(1, 0);
      stop();
      flush("w8");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
